// File: rtl/l1b_getir_yanitlayici_pkg.sv
// l1b_getir_yanitlayici_pkg: shared widths and helpers for the
// fetch-to-L1 instruction memory responder.
package l1b_getir_yanitlayici_pkg;

  localparam int PS_BIT = 32;
  localparam int VERI_BIT = 32;
  localparam logic HIGH = 1'b1;
  localparam logic LOW = 1'b0;

  function automatic logic [PS_BIT-1:0] kelime_hizala(
    input logic [PS_BIT-1:0] a
  );
    return {a[PS_BIT-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/l1b_getir_yanitlayici_yanit_fifo.sv
// yanit_fifo: synchronous response FIFO with occupancy count
// and a registered head word; push and pop may share a cycle.
module yanit_fifo #(
  parameter int GENISLIK = 32,
  parameter int DERINLIK = 4
) (
  input  logic                        clk_i,
  input  logic                        rstn_i,
  input  logic                        yaz_i,
  input  logic [GENISLIK-1:0]         yaz_veri_i,
  input  logic                        oku_i,
  output logic [GENISLIK-1:0]         bas_o,
  output logic                        bos_o,
  output logic [$clog2(DERINLIK):0]   doluluk_o
);

  localparam int IW = $clog2(DERINLIK);

  logic [GENISLIK-1:0] mem [DERINLIK];
  logic [IW-1:0] yaz_ptr, oku_ptr, oku_ptr_n;
  logic [IW:0] sayi_n;
  logic cek, dolu;

  assign bos_o = (doluluk_o == '0);
  assign dolu = (doluluk_o == (IW+1)'(DERINLIK));
  assign cek = oku_i && !bos_o;

  always_comb begin
    oku_ptr_n = oku_ptr + IW'(cek);
    sayi_n = doluluk_o + (IW+1)'(yaz_i) - (IW+1)'(cek);
  end

  always_ff @(posedge clk_i) begin
    if (yaz_i) mem[yaz_ptr] <= yaz_veri_i;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      yaz_ptr <= '0;
      oku_ptr <= '0;
      doluluk_o <= '0;
      bas_o <= '0;
    end else begin
      assert (!(yaz_i && dolu));
      yaz_ptr <= yaz_ptr + IW'(yaz_i);
      oku_ptr <= oku_ptr_n;
      doluluk_o <= sayi_n;
      // head lands on the word being written when it is the next to read
      if (sayi_n != '0) begin
        if (yaz_i && yaz_ptr == oku_ptr_n) bas_o <= yaz_veri_i;
        else bas_o <= mem[oku_ptr_n];
      end
    end
  end

endmodule

// File: rtl/l1b_getir_yanitlayici.sv
// l1b_getir_yanitlayici: issues getir1 fetches to fixed-latency BRAM
// and returns every word in order to getir2, credit-limited.
import l1b_getir_yanitlayici_pkg::*;

module l1b_getir_yanitlayici #(
  parameter int BELLEK_GECIKME = 2,
  parameter int FIFO_DERINLIK = 4
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic [PS_BIT-1:0]   g1_istek_adres_i,
  input  logic                g1_istek_gecerli_i,
  output logic                g1_istek_hazir_o,
  output logic [PS_BIT-1:0]   bellek_adres_o,
  output logic                bellek_oku_o,
  input  logic [VERI_BIT-1:0] bellek_veri_i,
  output logic [VERI_BIT-1:0] l1b_buyruk_o,
  output logic                l1b_buyruk_gecerli_o,
  input  logic                l1b_buyruk_hazir_i
);

  localparam int SW = $clog2(FIFO_DERINLIK) + 1;

  logic [1:0] rst_q;
  logic rst_n;
  logic [BELLEK_GECIKME-1:0] ucus_q;
  logic [SW-1:0] ucusta_q, doluluk;
  logic [SW:0] rezerve;
  logic kabul, yakala, cek, bos;

  // assert immediately, release two edges later
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) rst_q <= '0;
    else rst_q <= {rst_q[0], HIGH};
  end
  assign rst_n = rst_q[1];

  assign rezerve = {1'b0, doluluk} + {1'b0, ucusta_q};
  assign g1_istek_hazir_o = rst_n &&
    (rezerve < (SW+1)'(FIFO_DERINLIK));

  assign kabul = g1_istek_gecerli_i && g1_istek_hazir_o;
  assign bellek_oku_o = kabul;
  assign bellek_adres_o = kabul ? kelime_hizala(g1_istek_adres_i) : '0;

  assign yakala = ucus_q[BELLEK_GECIKME-1];
  assign l1b_buyruk_gecerli_o = !bos;
  assign cek = l1b_buyruk_gecerli_o && l1b_buyruk_hazir_i;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      ucus_q <= '0;
      ucusta_q <= '0;
    end else begin
      ucus_q <= (ucus_q << 1) | BELLEK_GECIKME'(kabul);
      unique case (1'b1)
        kabul && !yakala: ucusta_q <= ucusta_q + SW'(1);
        yakala && !kabul: ucusta_q <= ucusta_q - SW'(1);
        default: ;
      endcase
    end
  end

  yanit_fifo #(
    .GENISLIK(VERI_BIT),
    .DERINLIK(FIFO_DERINLIK)
  ) u_fifo (
    .clk_i      (clk_i),
    .rstn_i     (rst_n),
    .yaz_i      (yakala),
    .yaz_veri_i (bellek_veri_i),
    .oku_i      (cek),
    .bas_o      (l1b_buyruk_o),
    .bos_o      (bos),
    .doluluk_o  (doluluk)
  );

endmodule

// File: tb/tb_l1b_getir_yanitlayici.sv
// tb_l1b_getir_yanitlayici: directed and random fetch traffic checked
// against an in-order queue model of accepted requests.
module tb_l1b_getir_yanitlayici;

  localparam int G = 2;
  localparam int FD = 4;

  logic clk = 1'b0;
  logic rstn;
  logic [31:0] adres;
  logic gecerli;
  logic g1_hazir;
  logic [31:0] bellek_adres;
  logic bellek_oku;
  logic [31:0] bellek_veri;
  logic [31:0] buyruk;
  logic buyruk_gecerli;
  logic hazir;

  always #5 clk = ~clk;

  l1b_getir_yanitlayici #(
    .BELLEK_GECIKME(G),
    .FIFO_DERINLIK(FD)
  ) dut (
    .clk_i                (clk),
    .rstn_i               (rstn),
    .g1_istek_adres_i     (adres),
    .g1_istek_gecerli_i   (gecerli),
    .g1_istek_hazir_o     (g1_hazir),
    .bellek_adres_o       (bellek_adres),
    .bellek_oku_o         (bellek_oku),
    .bellek_veri_i        (bellek_veri),
    .l1b_buyruk_o         (buyruk),
    .l1b_buyruk_gecerli_o (buyruk_gecerli),
    .l1b_buyruk_hazir_i   (hazir)
  );

  function automatic logic [31:0] veri_of(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h0F1E2D3C;
  endfunction

  // BRAM: the word for the strobed address shows up G cycles later
  logic [31:0] bp [G];
  always @(posedge clk) begin
    bp[0] <= bellek_adres;
    for (int i = 1; i < G; i++) bp[i] <= bp[i-1];
  end
  assign bellek_veri = veri_of(bp[G-1]);

  int vektor = 0;
  int hata = 0;

  task automatic kontrol(input string etiket,
                         input logic [31:0] gozlenen,
                         input logic [31:0] beklenen);
    vektor++;
    if (gozlenen !== beklenen) begin
      hata++;
      $display("FAIL %s: got %h expected %h", etiket, gozlenen, beklenen);
    end
  endtask

  typedef struct {
    logic [31:0] veri;
    int          hazir_dongu;
  } kayit_t;

  kayit_t q[$];
  int kabul_say, cikis_say, dongu;
  bit izle;
  bit bek_gecerli;
  bit kabul;

  // model: a word is due G+1 cycles after its accept, strictly in order;
  // a request slot is free while fewer than FD are accepted but unpopped
  always @(negedge clk) begin
    if (izle) begin
      kontrol("g1_hazir", g1_hazir, (kabul_say - cikis_say) < FD);
      bek_gecerli = q.size() > 0 && q[0].hazir_dongu <= dongu;
      kontrol("gecerli", buyruk_gecerli, bek_gecerli);
      if (bek_gecerli) kontrol("veri", buyruk, q[0].veri);
      kabul = gecerli && g1_hazir;
      kontrol("oku", bellek_oku, kabul);
      if (buyruk_gecerli && hazir) begin
        if (q.size() > 0) void'(q.pop_front());
        cikis_say++;
      end
      if (kabul) begin
        kontrol("adres", bellek_adres, adres & 32'hFFFF_FFFC);
        q.push_back('{veri: veri_of(adres & 32'hFFFF_FFFC),
                      hazir_dongu: dongu + G + 1});
        kabul_say++;
      end
      dongu++;
    end
  end

  task automatic adim();
    @(posedge clk);
    #1;
  endtask

  task automatic sifirla();
    izle = 1'b0;
    rstn = 1'b0;
    q.delete();
    kabul_say = 0;
    cikis_say = 0;
    repeat (3) adim();
    rstn = 1'b1;
    repeat (3) adim();
    izle = 1'b1;
  endtask

  int b;

  initial begin
    gecerli = 1'b0;
    hazir = 1'b0;
    adres = '0;
    rstn = 1'b0;
    izle = 1'b0;
    dongu = 0;
    sifirla();
    kontrol("rst_g1_hazir", g1_hazir, 1);
    kontrol("rst_gecerli", buyruk_gecerli, 0);
    kontrol("rst_buyruk", buyruk, 0);
    kontrol("rst_oku", bellek_oku, 0);

    // single unaligned request
    hazir = 1'b1;
    adres = 32'h0000_0106;
    gecerli = 1'b1;
    #1;
    kontrol("tek_adres", bellek_adres, 32'h0000_0104);
    adim();
    gecerli = 1'b0;
    repeat (6) adim();

    // back-to-back stream
    for (int i = 0; i < 8; i++) begin
      adres = 32'(i * 4);
      gecerli = 1'b1;
      adim();
    end
    gecerli = 1'b0;
    repeat (8) adim();
    kontrol("akis_say", cikis_say, kabul_say);

    // backpressure
    hazir = 1'b0;
    gecerli = 1'b1;
    b = kabul_say;
    repeat (10) begin
      adres = $urandom;
      adim();
    end
    kontrol("bp_kabul", kabul_say - b, 4);
    kontrol("bp_g1_hazir", g1_hazir, 0);
    hazir = 1'b1;
    repeat (12) begin
      adres = $urandom;
      adim();
    end
    gecerli = 1'b0;
    repeat (8) adim();

    // drain of three outstanding requests
    hazir = 1'b0;
    for (int i = 0; i < 3; i++) begin
      adres = 32'h100 + 32'(i * 4);
      gecerli = 1'b1;
      adim();
    end
    gecerli = 1'b0;
    hazir = 1'b1;
    b = cikis_say;
    repeat (10) adim();
    kontrol("drain_say", cikis_say - b, 3);
    kontrol("drain_gecerli", buyruk_gecerli, 0);
    kontrol("drain_kredi", kabul_say - cikis_say, 0);

    // async reset with words in flight and buffered
    hazir = 1'b0;
    for (int i = 0; i < 4; i++) begin
      adres = 32'h200 + 32'(i * 4);
      gecerli = 1'b1;
      adim();
    end
    gecerli = 1'b0;
    kontrol("ar_dolu", buyruk_gecerli, 1);
    izle = 1'b0;
    rstn = 1'b0;
    #1;
    kontrol("ar_g1_hazir", g1_hazir, 0);
    kontrol("ar_oku", bellek_oku, 0);
    kontrol("ar_adres", bellek_adres, 0);
    kontrol("ar_gecerli", buyruk_gecerli, 0);
    kontrol("ar_buyruk", buyruk, 0);
    sifirla();
    hazir = 1'b1;
    repeat (8) adim();
    kontrol("ar_bayat", cikis_say, 0);

    // random traffic
    repeat (5000) begin
      gecerli = ($urandom % 4) != 0;
      hazir = ($urandom % 3) != 0;
      adres = $urandom;
      adim();
    end
    gecerli = 1'b0;
    hazir = 1'b1;
    repeat (12) adim();
    kontrol("rnd_say", cikis_say, kabul_say);
    kontrol("rnd_kuyruk", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vektor, hata);
    $finish;
  end

endmodule
